ahbl_sram_slave: RTL and testbench

Parametrised AHB-Lite memory slave: a byte-addressable SRAM behind the `ahbl` slave modport, generalised in data width, depth, base address and programmable wait states. It adds sub-word writes via HSIZE, a two-cycle ERROR response for illegal accesses, and read-after-write forwarding so that back-to-back transfers run at full rate. It sits behind the AHB-Lite decoder/mux as a generic on-chip RAM or scratchpad.

---
 rtl/ahbl_common.sv | 40 ++++
 rtl/ahbl_sram_slave_if.sv | 26 ++
 rtl/sram_be_array.sv | 29 ++
 rtl/ahbl_sram_slave.sv | 153 +++++++++++++++
 tb/tb_ahbl_sram_slave.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ahbl_common.sv
// Shared AHB-Lite types: transfer/burst encodings, size codes and the
// SRAM slave data-phase state.
package ahbl_common;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } HBURST_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } HTRANS_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } ahbl_sram_state_t;

  function automatic logic [31:0] size_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/ahbl_sram_slave_if.sv
// AHB-Lite slave-side bus bundle, parametrised in data width.
interface ahbl_sram_slave_if #(
  parameter int DW = 32
);
  logic          HSELx;
  logic [31:0]   HADDR;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [1:0]    HTRANS;
  logic          HREADY;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADYOUT;
  logic          HRESP;

  modport master (
    output HSELx, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HREADY, HWDATA,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSELx, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HREADY, HWDATA,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/sram_be_array.sv
// Word-organised SRAM with one synchronous read port and one byte-enable
// write port; storage is never reset.
module sram_be_array #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DW-1:0]            rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DW/8-1:0]          wr_strb,
  input  logic [DW-1:0]            wr_data
);
  localparam int NB = DW / 8;

  logic [DW-1:0] mem [DEPTH];

  // A read and a write to the same word on one edge return the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_strb[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM slave: address decode, error check, wait-state FSM,
// byte-lane strobes and write-to-read forwarding in front of the array.
module ahbl_sram_slave
  import ahbl_common::*;
#(
  parameter int          DW          = 32,
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input logic              HCLK,
  input logic              HRESET,
  ahbl_sram_slave_if.slave bus
);
  localparam int          NB   = DW / 8;
  localparam int          LB   = $clog2(NB);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'(NB);
  localparam logic [2:0]  WS   = 3'(WAIT_STATES);

  function automatic logic [NB-1:0] lane_strobe(input logic [2:0] size,
                                                 input logic [LB-1:0] lane);
    logic [31:0] ones;
    ones = (32'd1 << size_bytes(size)) - 32'd1;
    return NB'(ones << lane);
  endfunction

  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] base,
                                                input logic [DW-1:0] fwd,
                                                input logic [NB-1:0] mask);
    logic [DW-1:0] merged;
    for (int i = 0; i < NB; i++)
      merged[8*i +: 8] = mask[i] ? fwd[8*i +: 8] : base[8*i +: 8];
    return merged;
  endfunction

  ahbl_sram_state_t state;
  logic [2:0]       cnt;
  logic             hready_q;
  logic             hresp_q;

  logic [31:0]      off;
  logic             in_range;
  logic             size_ok;
  logic             aligned;
  logic             addr_err;
  logic             slot_free;
  logic             acc;
  logic             ren;
  logic             wen;
  logic [AW-1:0]    word_p0;

  logic [AW-1:0]    word_p1;
  logic             write_p1;
  logic [NB-1:0]    strb_p1;
  logic [NB-1:0]    fwd_mask_p1;
  logic [DW-1:0]    fwd_data_p1;
  logic [DW-1:0]    rd_word;

  logic             unused_bits;
  assign unused_bits = ^{bus.HBURST, bus.HTRANS[0]};

  // Address phase: decode and legality check
  assign off       = bus.HADDR - BASE_ADDR;
  assign in_range  = (bus.HADDR >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign size_ok   = (32'd8 << bus.HSIZE) <= 32'(DW);
  assign aligned   = (bus.HADDR & (size_bytes(bus.HSIZE) - 32'd1)) == 32'd0;
  assign addr_err  = !(in_range && size_ok && aligned);
  assign word_p0   = off[LB +: AW];

  // WAIT and ERR1 hold HREADY low, so a new accept is only possible here.
  assign slot_free = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign acc       = bus.HSELx && bus.HREADY && bus.HTRANS[1] && slot_free;
  assign ren       = acc && !addr_err && !bus.HWRITE;
  assign wen       = (state == ST_DATA) && write_p1 && !HRESET;

  // Data phase registers
  always_ff @(posedge HCLK) begin
    if (acc) begin
      word_p1  <= word_p0;
      write_p1 <= bus.HWRITE;
      strb_p1  <= lane_strobe(bus.HSIZE, bus.HADDR[LB-1:0]);
    end
    if (ren) begin
      fwd_mask_p1 <= (wen && (word_p1 == word_p0)) ? strb_p1 : '0;
      fwd_data_p1 <= bus.HWDATA;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state    <= ST_DATA;
            hready_q <= 1'b1;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          if (acc && addr_err) begin
            state    <= ST_ERR1;
            hready_q <= 1'b0;
            hresp_q  <= 1'b1;
          end else if (acc && (WS != 3'd0)) begin
            state    <= ST_WAIT;
            cnt      <= WS;
            hready_q <= 1'b0;
            hresp_q  <= 1'b0;
          end else if (acc) begin
            state    <= ST_DATA;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end else begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  sram_be_array #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_array (
    .clk    (HCLK),
    .rd_en  (ren),
    .rd_addr(word_p0),
    .rd_data(rd_word),
    .wr_en  (wen),
    .wr_addr(word_p1),
    .wr_strb(strb_p1),
    .wr_data(bus.HWDATA)
  );

  // Read result: array word with any same-edge write lanes overlaid
  assign bus.HRDATA    = ((state == ST_DATA) && !write_p1)
                         ? merge_lanes(rd_word, fwd_data_p1, fwd_mask_p1) : '0;
  assign bus.HREADYOUT = hready_q;
  assign bus.HRESP     = hresp_q;
endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Directed bench for ahbl_sram_slave: three instances cover zero-wait 32-bit,
// three-wait-state 32-bit and zero-wait 64-bit configurations.
module tb_ahbl_sram_slave;
  localparam logic [31:0] B0 = 32'h1000_0000;
  localparam logic [31:0] B1 = 32'h2000_0000;
  localparam logic [31:0] B2 = 32'h3000_0000;

  logic        clk;
  logic        rst;
  logic [2:0]  sel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [63:0] hwdata;
  int          n_chk;
  int          n_fail;
  int          low;

  ahbl_sram_slave_if #(.DW(32)) if0 ();
  ahbl_sram_slave_if #(.DW(32)) if1 ();
  ahbl_sram_slave_if #(.DW(64)) if2 ();

  assign if0.HSELx = sel[0];  assign if1.HSELx = sel[1];  assign if2.HSELx = sel[2];
  assign if0.HADDR = haddr;   assign if1.HADDR = haddr;   assign if2.HADDR = haddr;
  assign if0.HWRITE = hwrite; assign if1.HWRITE = hwrite; assign if2.HWRITE = hwrite;
  assign if0.HSIZE = hsize;   assign if1.HSIZE = hsize;   assign if2.HSIZE = hsize;
  assign if0.HTRANS = htrans; assign if1.HTRANS = htrans; assign if2.HTRANS = htrans;
  assign if0.HBURST = 3'd0;   assign if1.HBURST = 3'd0;   assign if2.HBURST = 3'd0;
  assign if0.HWDATA = hwdata[31:0];
  assign if1.HWDATA = hwdata[31:0];
  assign if2.HWDATA = hwdata;
  assign if0.HREADY = if0.HREADYOUT;
  assign if1.HREADY = if1.HREADYOUT;
  assign if2.HREADY = if2.HREADYOUT;

  ahbl_sram_slave #(.DW(32), .DEPTH(1024), .BASE_ADDR(B0), .WAIT_STATES(0))
    u0 (.HCLK(clk), .HRESET(rst), .bus(if0));
  ahbl_sram_slave #(.DW(32), .DEPTH(256), .BASE_ADDR(B1), .WAIT_STATES(3))
    u1 (.HCLK(clk), .HRESET(rst), .bus(if1));
  ahbl_sram_slave #(.DW(64), .DEPTH(256), .BASE_ADDR(B2), .WAIT_STATES(0))
    u2 (.HCLK(clk), .HRESET(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ap(input logic [31:0] a, input logic w, input logic [2:0] s);
    haddr  = a;
    hwrite = w;
    hsize  = s;
    htrans = 2'b10;
  endtask

  task automatic idle();
    htrans = 2'b00;
  endtask

  task automatic wait_ready1(output int lows);
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if1.HREADYOUT === 1'b1) return;
      lows++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1; sel = 3'b000; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    htrans = 2'b00; hwdata = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_hreadyout", 64'(if0.HREADYOUT), 64'd1);
    chk("rst_hresp",     64'(if0.HRESP),     64'd0);
    chk("rst_hrdata",    64'(if0.HRDATA),    64'd0);
    tick(); rst = 1'b0;

    // Zero-wait write then read of the same word
    sel = 3'b001;
    tick(); ap(B0 + 32'h10, 1'b1, 3'd2);
    tick(); hwdata = 64'hDEADBEEF; ap(B0 + 32'h10, 1'b0, 3'd2);
    @(negedge clk);
    chk("b2b_wr_ready", 64'(if0.HREADYOUT), 64'd1);
    tick(); idle();
    @(negedge clk);
    chk("b2b_rd_ready", 64'(if0.HREADYOUT), 64'd1);
    chk("b2b_rd_data",  64'(if0.HRDATA),    64'hDEADBEEF);

    // Sub-word writes
    tick(); ap(B0 + 32'h10, 1'b1, 3'd2);
    tick(); hwdata = 64'h11223344; ap(B0 + 32'h11, 1'b1, 3'd0);
    tick(); hwdata = 64'h0000AA00; ap(B0 + 32'h10, 1'b0, 3'd2);
    tick(); idle();
    @(negedge clk);
    chk("byte_wr_data", 64'(if0.HRDATA), 64'h1122AA44);
    tick(); ap(B0 + 32'h12, 1'b1, 3'd1);
    tick(); hwdata = 64'hBEEF0000; idle();
    @(negedge clk);
    chk("wr_phase_hrdata_zero", 64'(if0.HRDATA), 64'd0);
    tick(); ap(B0 + 32'h10, 1'b0, 3'd2);
    tick(); idle();
    @(negedge clk);
    chk("half_wr_data", 64'(if0.HRDATA), 64'hBEEFAA44);

    // Out-of-range address
    tick(); ap(B0 + 32'h1000, 1'b0, 3'd2);
    tick(); idle();
    @(negedge clk);
    chk("oor_err1_ready", 64'(if0.HREADYOUT), 64'd0);
    chk("oor_err1_resp",  64'(if0.HRESP),     64'd1);
    tick();
    @(negedge clk);
    chk("oor_err2_ready", 64'(if0.HREADYOUT), 64'd1);
    chk("oor_err2_resp",  64'(if0.HRESP),     64'd1);
    chk("oor_err2_data",  64'(if0.HRDATA),    64'd0);
    tick();
    @(negedge clk);
    chk("oor_after_resp", 64'(if0.HRESP), 64'd0);

    // Misaligned half write, next transfer accepted during ERR2
    tick(); ap(B0 + 32'h11, 1'b1, 3'd1);
    tick(); hwdata = 64'hFFFFFFFF; idle();
    @(negedge clk);
    chk("mis_err1_ready", 64'(if0.HREADYOUT), 64'd0);
    chk("mis_err1_resp",  64'(if0.HRESP),     64'd1);
    tick(); ap(B0 + 32'h10, 1'b0, 3'd2);
    @(negedge clk);
    chk("mis_err2_ready", 64'(if0.HREADYOUT), 64'd1);
    chk("mis_err2_resp",  64'(if0.HRESP),     64'd1);
    tick(); idle();
    @(negedge clk);
    chk("mis_rd_resp",      64'(if0.HRESP),  64'd0);
    chk("mis_mem_unchanged", 64'(if0.HRDATA), 64'hBEEFAA44);

    // Wait states: pipelined read held behind a write
    tick(); sel = 3'b010; idle();
    tick(); ap(B1 + 32'h4, 1'b1, 3'd2);
    tick(); hwdata = 64'hCAFEF00D; ap(B1 + 32'h4, 1'b0, 3'd2);
    wait_ready1(low);
    chk("ws_wr_low_cycles", 64'(low), 64'd3);
    chk("ws_wr_resp",       64'(if1.HRESP), 64'd0);
    tick(); idle();
    wait_ready1(low);
    chk("ws_rd_low_cycles", 64'(low), 64'd3);
    chk("ws_rd_data",       64'(if1.HRDATA), 64'hCAFEF00D);

    // Reset during the wait of a write
    tick(); ap(B1 + 32'h4, 1'b1, 3'd2);
    tick(); hwdata = 64'h12345678; idle();
    @(negedge clk);
    chk("rstw_wait_ready", 64'(if1.HREADYOUT), 64'd0);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("rstw_ready", 64'(if1.HREADYOUT), 64'd1);
    chk("rstw_resp",  64'(if1.HRESP),     64'd0);
    chk("rstw_data",  64'(if1.HRDATA),    64'd0);
    tick(); ap(B1 + 32'h4, 1'b0, 3'd2);
    tick(); idle();
    wait_ready1(low);
    chk("rstw_rd_low",   64'(low), 64'd3);
    chk("rstw_old_word", 64'(if1.HRDATA), 64'hCAFEF00D);

    // 64-bit instance: last word, upper-lane word write, boundaries
    tick(); sel = 3'b100; idle();
    tick(); ap(B2 + 32'h7F8, 1'b1, 3'd3);
    tick(); hwdata = 64'h0123456789ABCDEF; ap(B2 + 32'h7F8, 1'b0, 3'd3);
    @(negedge clk);
    chk("w64_dword_ready", 64'(if2.HREADYOUT), 64'd1);
    chk("w64_dword_resp",  64'(if2.HRESP),     64'd0);
    tick(); ap(B2 + 32'h7FC, 1'b1, 3'd2);
    @(negedge clk);
    chk("w64_last_word", if2.HRDATA, 64'h0123456789ABCDEF);
    tick(); hwdata = 64'hAAAABBBB00000000; ap(B2 + 32'h7F8, 1'b0, 3'd3);
    tick(); idle();
    @(negedge clk);
    chk("w64_upper_lanes", if2.HRDATA, 64'hAAAABBBB89ABCDEF);
    tick(); ap(B2 + 32'h800, 1'b0, 3'd3);
    tick(); idle();
    @(negedge clk);
    chk("w64_oor_ready", 64'(if2.HREADYOUT), 64'd0);
    chk("w64_oor_resp",  64'(if2.HRESP),     64'd1);
    tick();
    @(negedge clk);
    chk("w64_oor_err2", 64'({if2.HREADYOUT, if2.HRESP}), 64'd3);
    tick(); ap(B2, 1'b0, 3'd4);
    tick(); idle();
    @(negedge clk);
    chk("w64_size4_ready", 64'(if2.HREADYOUT), 64'd0);
    chk("w64_size4_resp",  64'(if2.HRESP),     64'd1);
    tick(); tick();
    @(negedge clk);
    chk("w64_idle_resp", 64'(if2.HRESP), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
